// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer feeding the control decoder: counts phases, handles
// run/stop and single-step buttons, and halts at the end of an HLT instruction.
module phase_sequencer #(
  parameter int unsigned NUM_PHASES = 5,
  parameter int unsigned PHASE_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec,
  input  logic               step,
  input  logic               stop_flag,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_en,
  output logic               instr_done,
  output logic               running,
  output logic               halted
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StStep = 2'd2;
  localparam logic [1:0] StHalt = 2'd3;

  localparam logic [PHASE_W-1:0] LastPhase = PHASE_W'(NUM_PHASES - 1);

  logic [1:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               stop_req_q, stop_req_d;
  logic               exec_q, step_q;
  logic               exec_rise, step_rise;
  logic               last_phase;
  logic               live;

  assign exec_rise  = exec & ~exec_q;
  assign step_rise  = step & ~step_q;
  assign last_phase = (phase_q == LastPhase);
  assign live       = (state_q == StRun) || (state_q == StStep);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    stop_req_d = stop_req_q;
    case (state_q)
      StRun: begin
        if (exec_rise) begin
          stop_req_d = 1'b1;
        end
        if (last_phase) begin
          phase_d = '0;
          if (stop_flag) begin
            state_d = StHalt;
          end else if (stop_req_q || exec_rise) begin
            state_d = StIdle;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
        // stop_req only lives while in RUN
        if (state_d != StRun) begin
          stop_req_d = 1'b0;
        end
      end
      StStep: begin
        stop_req_d = 1'b0;
        if (last_phase) begin
          phase_d = '0;
          state_d = stop_flag ? StHalt : StIdle;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        // IDLE and HALT share start-up behaviour; exec wins over step
        phase_d    = '0;
        stop_req_d = 1'b0;
        if (exec_rise) begin
          state_d = StRun;
        end else if (step_rise) begin
          state_d = StStep;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      stop_req_q <= 1'b0;
      // Capture current levels so a button held through reset gives no edge
      exec_q     <= exec;
      step_q     <= step;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      stop_req_q <= stop_req_d;
      exec_q     <= exec;
      step_q     <= step;
    end
  end

  assign phase      = phase_q;
  assign phase_en   = live;
  assign running    = live;
  assign instr_done = live && last_phase;
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a table of per-cycle vectors followed by
// hand-written sequences for step, simultaneous-button, HLT-with-exec and reset cases.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       exec = 1'b0;
  logic       step = 1'b0;
  logic       stop_flag = 1'b0;
  logic [2:0] phase;
  logic       phase_en, instr_done, running, halted;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       rst;
    logic       exec;
    logic       step;
    logic       stop;
    logic [2:0] ph;
    logic       en;
    logic       done;
    logic       hlt;
  } vec_t;

  vec_t vecs[$];

  phase_sequencer #(
    .NUM_PHASES(5),
    .PHASE_W   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .exec      (exec),
    .step      (step),
    .stop_flag (stop_flag),
    .phase     (phase),
    .phase_en  (phase_en),
    .instr_done(instr_done),
    .running   (running),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] ph, input logic en,
                       input logic done, input logic hlt);
    logic [6:0] got, exp;
    got = {phase, phase_en, instr_done, running, halted};
    exp = {ph, en, done, en, hlt};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got phase=%0d en=%b done=%b run=%b halt=%b, want phase=%0d en=%b done=%b run=%b halt=%b",
               name, phase, phase_en, instr_done, running, halted, ph, en, done, en, hlt);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic s, input logic sf,
                     input logic [2:0] ph, input logic en, input logic done, input logic hlt);
    vec_t v;
    v = '{rst: r, exec: e, step: s, stop: sf, ph: ph, en: en, done: done, hlt: hlt};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic sf);
    rst = r; exec = e; step = s; stop_flag = sf;
  endtask

  initial begin
    // Each row: inputs present before an edge, outputs expected just after it.
    // Reset with exec held, then exec stays high: no start.
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // exec pressed for 3 cycles: continuous run 0..4,0
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    // exec re-pressed during phase 1: finish instruction, then idle
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // stop_flag in phase 2 ignored, in phase 4 halts
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 1, 3, 1, 0, 0);
    add(0, 0, 0, 0, 4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 4, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // exec resumes from HALT
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].exec, vecs[i].step, vecs[i].stop);
      tick();
      check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].en, vecs[i].done, vecs[i].hlt);
    end

    // Single step from IDLE: exactly five live cycles then IDLE
    drive(1, 0, 0, 0);
    tick();
    check("step_reset", 0, 0, 0, 0);
    drive(0, 0, 1, 0);
    tick();
    check("step_p0", 0, 1, 0, 0);
    for (int p = 1; p < 5; p++) begin
      tick();
      check($sformatf("step_p%0d", p), 3'(p), 1'b1, (p == 4), 1'b0);
    end
    tick();
    check("step_end", 0, 0, 0, 0);
    tick();
    check("step_held_idle", 0, 0, 0, 0);

    // exec and step rise together in IDLE: RUN wins (still live after one instruction)
    drive(0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0);
    tick();
    check("both_p0", 0, 1, 0, 0);
    drive(0, 0, 0, 0);
    for (int p = 1; p < 5; p++) tick();
    check("both_p4", 4, 1, 1, 0);
    tick();
    check("both_still_run", 0, 1, 0, 0);
    for (int p = 1; p < 5; p++) tick();
    check("both_p4b", 4, 1, 1, 0);

    // exec edge together with stop_flag in phase 4: HALT takes priority
    drive(0, 1, 0, 1);
    tick();
    check("exec_stop_halt", 0, 0, 0, 1);

    // step from HALT, exec press during STEP ignored, then IDLE
    drive(0, 0, 1, 0);
    tick();
    check("halt_step_p0", 0, 1, 0, 0);
    drive(0, 1, 0, 0);
    tick();
    check("halt_step_p1", 1, 1, 0, 0);
    drive(0, 0, 0, 0);
    for (int p = 2; p < 5; p++) tick();
    check("halt_step_p4", 4, 1, 1, 0);
    tick();
    check("halt_step_idle", 0, 0, 0, 0);

    // Reset asserted at phase 3 abandons the instruction
    drive(0, 1, 0, 0);
    tick();
    check("rst_run_p0", 0, 1, 0, 0);
    drive(0, 0, 0, 0);
    for (int p = 1; p < 4; p++) tick();
    check("rst_run_p3", 3, 1, 0, 0);
    drive(1, 0, 0, 0);
    tick();
    check("rst_mid", 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    tick();
    check("rst_after", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
